axis_row_producer: RTL
======================

AXIS_ROW_PRODUCER -- requirements
Module: axis_row_producer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: output stream width in bits; legal values 512 and 1024, and 2048 SHALL be divisible by DATA_WIDTH/8.
REQ-002 SHALL use a single clock, clk; reset is synchronous and active-high, port reset.
REQ-003 clk  input  1  sole clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a dataset.
REQ-006 row_count  input  64  rows per dataset, sampled on accepted start.
REQ-007 seed  input  32  initial data-pattern value, sampled on accepted start.
REQ-008 gap_cycles  input  16  idle cycles between consecutive rows, sampled on accepted start.
REQ-009 inject_error  input  1  pulse: corrupt the next data beat.
REQ-010 idle  output  1  high when no dataset is active or pending.
REQ-011 rows_sent  output  64  rows completed in the current dataset.
REQ-012 AXIS_OUT_TDATA/TVALID/TREADY  output/output/input  DATA_WIDTH/1/1  row/AXI packet stream.
REQ-013 AXI_REQ_TDATA/TVALID/TREADY  input/input/output  72/1/1  AXI requests to forward: [31:0] addr, [63:32] data, [64] mode.

Function
REQ-014 States: IDLE, HDR, DATA, TRL, GAP, AXI.
REQ-015 Handshake: a beat transfers when TVALID&TREADY; while TVALID&~TREADY, TDATA SHALL stay stable; TVALID never drops without a transfer (except reset).
REQ-016 An accepted start in IDLE with row_count!=0 SHALL: clear rows_sent, load V<=seed, drive idle low, and present the header beat on the next cycle.
REQ-017 start with row_count==0 SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-018 Header beat: [511:504]=0x02, [63:0]=row index (0-based); all other bits zero.
REQ-019 DATA: exactly 2048/(DATA_WIDTH/8) beats (32 at 512); 32-bit lane k = V ^ P[k mod 4] with P={0,FFFFFFFF,AAAAAAAA,55555555}; V increments by 1 (mod 2^32) after each data transfer.
REQ-020 Trailer beat: [511:504]=0x03, [63:0]=row index; rows_sent increments on its transfer.
REQ-021 After trailer: if rows_sent==row_count, go to IDLE (idle high next cycle); else GAP for gap_cycles cycles, then HDR (gap 0 = header on the next cycle).
REQ-022 AXI_REQ_TREADY SHALL be high only in IDLE and GAP; an accepted request enters AXI and presents one beat: [511:504]=0x01, [64:0]=AXI_REQ_TDATA[64:0], other bits zero.
REQ-023 After the AXI beat transfers, SHALL return to the originating state; the GAP counter is frozen during AXI.
REQ-024 start and AXI_REQ_TVALID in the same IDLE cycle: the AXI request wins; start is held pending and the header follows the AXI beat; idle is low while start is pending.
REQ-025 inject_error SHALL set a sticky flag; the next data beat flips lane 1 bit 0, then the flag clears; a pulse during a beat already presented applies to the following data beat.
REQ-026 Bits above 511 at DATA_WIDTH=1024 SHALL continue the lane pattern in DATA beats and be zero elsewhere.

Reset
REQ-027 On reset: state IDLE, AXIS_OUT_TVALID=0, AXI_REQ_TREADY=0, idle=1, rows_sent=0, TDATA=0, error flag and pending start cleared.
REQ-028 Reset mid-packet SHALL abort immediately with no completion beat; TVALID is low on the cycle after reset asserts.

Structure
REQ-029 Packet-type codes (0x01, 0x02, 0x03), the pattern constants P, and ROW_BYTES=2048 SHALL live in a shared package used by both the producer and the consumer.
REQ-030 The lane-pattern generator SHALL be one sub-module, row_pattern_gen (V -> DATA_WIDTH word).

Verification
REQ-031 row_count=2, seed=0x1000, gap=0, TREADY=1 -> 68 beats: header row 0; data V=0x1000..0x101F (first beat lane1=0xFFFFEFFF); trailer 0x03; then row 1; rows_sent=2; idle=1.
REQ-032 Same stimulus with TREADY toggling 1/0 -> identical beat sequence; TDATA unchanged across every stalled cycle.
REQ-033 gap=5, AXI request addr 0x40/data 0x1234/mode 1 during GAP -> type-0x01 beat with [31:0]=0x40, [63:32]=0x1234, [64]=1 between trailer 0 and header 1.
REQ-034 inject_error during row 0 -> exactly one data beat has lane1 bit0 flipped; the downstream consumer error count is 1.
REQ-035 reset asserted during DATA beat 10 -> next cycle TVALID=0, idle=1, rows_sent=0; a new start yields header row 0.
REQ-036 start with row_count=0 -> no beats; idle stays 1.

Source files
------------

// File: rtl/axis_row_producer_pkg.sv
// Shared constants for the row/AXI packet stream: packet-type codes,
// data lane pattern and the row payload size.
package axis_row_producer_pkg;

    // Packet-type codes carried in bits [511:504] of non-data beats
    localparam logic [7:0] PKT_AXI = 8'h01;
    localparam logic [7:0] PKT_HDR = 8'h02;
    localparam logic [7:0] PKT_TRL = 8'h03;

    // Payload bytes per row; data beats per row = ROW_BYTES / (DATA_WIDTH/8)
    localparam int ROW_BYTES = 2048;

    // Lane k of a data beat is V ^ PAT[k mod 4]
    localparam logic [3:0][31:0] PAT = {32'h5555_5555, 32'hAAAA_AAAA,
                                        32'hFFFF_FFFF, 32'h0000_0000};

endpackage

// File: rtl/axis_row_producer_if.sv
// Output packet stream plus the AXI-request side channel that gets
// forwarded into that stream.
interface axis_row_producer_if #(
    parameter int DATA_WIDTH = 512
) ();
    logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA;
    logic                  AXIS_OUT_TVALID;
    logic                  AXIS_OUT_TREADY;
    logic [71:0]           AXI_REQ_TDATA;
    logic                  AXI_REQ_TVALID;
    logic                  AXI_REQ_TREADY;

    modport master (
        output AXIS_OUT_TDATA, AXIS_OUT_TVALID,
        input  AXIS_OUT_TREADY,
        input  AXI_REQ_TDATA, AXI_REQ_TVALID,
        output AXI_REQ_TREADY
    );

    modport slave (
        input  AXIS_OUT_TDATA, AXIS_OUT_TVALID,
        output AXIS_OUT_TREADY,
        output AXI_REQ_TDATA, AXI_REQ_TVALID,
        input  AXI_REQ_TREADY
    );
endinterface

// File: rtl/axis_row_producer_row_pattern_gen.sv
// Expands the 32-bit pattern value V into a full data beat: every 32-bit
// lane is V xor'ed with the repeating four-entry pattern table.
module row_pattern_gen
    import axis_row_producer_pkg::*;
#(
    parameter int DATA_WIDTH = 512
) (
    input  logic [31:0]           v,
    output logic [DATA_WIDTH-1:0] word
);
    for (genvar k = 0; k < DATA_WIDTH / 32; k++) begin : g_lane
        assign word[32*k +: 32] = v ^ PAT[k % 4];
    end
endmodule

// File: rtl/axis_row_producer.sv
// Row packet producer: per row emits header, ROW_BYTES of patterned data and
// a trailer, with programmable idle gaps between rows. AXI requests arriving
// while idle or in a gap are forwarded as single type-0x01 beats.
// Output beats are registered; a new beat is loaded only when the current
// one transfers, so TDATA stays stable through back-pressure.
module axis_row_producer
    import axis_row_producer_pkg::*;
#(
    parameter int DATA_WIDTH = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] row_count,
    input  logic [31:0] seed,
    input  logic [15:0] gap_cycles,
    input  logic        inject_error,
    output logic        idle,
    output logic [63:0] rows_sent,
    axis_row_producer_if.master bus
);
    localparam int         BEATS     = ROW_BYTES / (DATA_WIDTH / 8);
    localparam logic [5:0] LAST_BEAT = 6'(BEATS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_TRL  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_AXI  = 3'd5;

    logic [2:0]            state, ret_state;
    logic [31:0]           v;
    logic [63:0]           row_cnt_q;
    logic [15:0]           gap_q, gap_cnt;
    logic [5:0]            beat_cnt;
    logic                  err_flag, start_pend;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;

    logic                  xfer, req_acc, start_ok, err_now;
    logic [31:0]           pat_v;
    logic [DATA_WIDTH-1:0] pat_word, data_word;
    logic [63:0]           rows_next;
    logic                  unused_req_bits;

    function automatic logic [DATA_WIDTH-1:0] mk_beat(input logic [7:0] t,
                                                      input logic [64:0] p);
        logic [DATA_WIDTH-1:0] w;
        w            = '0;
        w[511:504]   = t;
        w[64:0]      = p;
        return w;
    endfunction

    assign bus.AXIS_OUT_TDATA  = tdata;
    assign bus.AXIS_OUT_TVALID = tvalid;
    assign bus.AXI_REQ_TREADY  = !reset && (state == S_IDLE || state == S_GAP);

    assign xfer      = tvalid && bus.AXIS_OUT_TREADY;
    assign req_acc   = bus.AXI_REQ_TREADY && bus.AXI_REQ_TVALID;
    assign start_ok  = start && (row_count != 64'd0);
    // A pulse arriving while a beat is loaded still hits the beat being loaded
    assign err_now   = err_flag || inject_error;
    // In DATA the next beat to load uses the value after the current transfer
    assign pat_v     = (state == S_DATA) ? v + 32'd1 : v;
    assign rows_next = rows_sent + 64'd1;
    assign unused_req_bits = ^bus.AXI_REQ_TDATA[71:65];

    // Idle also covers forwarding an AXI beat on behalf of the idle state
    assign idle = !start_pend &&
                  (state == S_IDLE || (state == S_AXI && ret_state == S_IDLE));

    row_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_pat (
        .v    (pat_v),
        .word (pat_word)
    );

    // Error injection flips lane 1 bit 0 of the data beat being loaded
    always_comb begin
        data_word     = pat_word;
        data_word[32] = pat_word[32] ^ err_now;
    end

    // Packet sequencing FSM and registered output beat
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ret_state  <= S_IDLE;
            v          <= '0;
            row_cnt_q  <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            beat_cnt   <= '0;
            err_flag   <= 1'b0;
            start_pend <= 1'b0;
            rows_sent  <= '0;
            tdata      <= '0;
            tvalid     <= 1'b0;
        end else begin
            if (inject_error) err_flag <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        row_cnt_q <= row_count;
                        gap_q     <= gap_cycles;
                        v         <= seed;
                        rows_sent <= '0;
                    end
                    if (req_acc) begin
                        tdata      <= mk_beat(PKT_AXI, bus.AXI_REQ_TDATA[64:0]);
                        tvalid     <= 1'b1;
                        ret_state  <= S_IDLE;
                        state      <= S_AXI;
                        start_pend <= start_ok;
                    end else if (start_ok) begin
                        tdata  <= mk_beat(PKT_HDR, 65'd0);
                        tvalid <= 1'b1;
                        state  <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        tdata    <= data_word;
                        beat_cnt <= '0;
                        state    <= S_DATA;
                        if (err_now) err_flag <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        v <= v + 32'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            tdata <= mk_beat(PKT_TRL, {1'b0, rows_sent});
                            state <= S_TRL;
                        end else begin
                            tdata    <= data_word;
                            beat_cnt <= beat_cnt + 6'd1;
                            if (err_now) err_flag <= 1'b0;
                        end
                    end
                end
                S_TRL: begin
                    if (xfer) begin
                        rows_sent <= rows_next;
                        if (rows_next == row_cnt_q) begin
                            tvalid <= 1'b0;
                            state  <= S_IDLE;
                        end else if (gap_q == 16'd0) begin
                            tdata <= mk_beat(PKT_HDR, {1'b0, rows_next});
                            state <= S_HDR;
                        end else begin
                            gap_cnt <= gap_q;
                            tvalid  <= 1'b0;
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (req_acc) begin
                        tdata     <= mk_beat(PKT_AXI, bus.AXI_REQ_TDATA[64:0]);
                        tvalid    <= 1'b1;
                        ret_state <= S_GAP;
                        state     <= S_AXI;
                    end else if (gap_cnt == 16'd1) begin
                        tdata  <= mk_beat(PKT_HDR, {1'b0, rows_sent});
                        tvalid <= 1'b1;
                        state  <= S_HDR;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                S_AXI: begin
                    if (xfer) begin
                        if (start_pend) begin
                            start_pend <= 1'b0;
                            tdata      <= mk_beat(PKT_HDR, 65'd0);
                            state      <= S_HDR;
                        end else begin
                            tvalid <= 1'b0;
                            state  <= ret_state;
                        end
                    end
                end
                default: begin
                    tvalid <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule
